// File: rtl/dilithium_job_sched.sv
// Dilithium job scheduler: accepts one job descriptor at a time, starts the
// core, forwards cmd_len host words into the core input stream, then waits
// for the core's final output beat. A watchdog aborts stalled jobs by
// pulsing the core reset, and every job ends with a one-cycle done pulse
// that carries a completion status.
module dilithium_job_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned LEN_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [2:0]       cmd_sec_lvl,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             core_start,
  output logic [1:0]       core_mode,
  output logic [2:0]       core_sec_lvl,
  output logic             core_rst,
  output logic             core_valid_i,
  input  logic             core_ready_i,
  output logic [63:0]      core_data_i,
  input  logic             core_valid_o,
  input  logic             core_ready_o,
  input  logic             core_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [15:0]      jobs_ok
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FEED, S_DRAIN, S_RECOVER, S_DONE
  } state_t;

  state_t           state, next_state;
  logic [1:0]       next_status;
  logic [1:0]       job_mode;
  logic [2:0]       job_sec_lvl;
  logic [LEN_W-1:0] remaining;
  logic [WD_W-1:0]  wd_cnt;
  logic             rec_cnt;
  logic [1:0]       status_q;
  logic [15:0]      jobs_ok_q;

  logic cmd_fire, cmd_legal, feeding, in_hs, out_hs, last_hs, wd_expire;

  assign cmd_fire  = cmd_valid && (state == S_IDLE);
  assign cmd_legal = (cmd_mode <= 2'd2) &&
                     ((cmd_sec_lvl == 3'd2) || (cmd_sec_lvl == 3'd3) || (cmd_sec_lvl == 3'd5));
  assign feeding   = (state == S_FEED) && (remaining != '0);
  assign in_hs     = feeding && s_valid && core_ready_i;
  assign out_hs    = core_valid_o && core_ready_o;
  assign last_hs   = out_hs && core_last;
  // Expiry fires on the cycle the counter would reach TIMEOUT_CYCLES.
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !in_hs && !out_hs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and completion-status selection
  always_comb begin
    next_state  = state;
    next_status = status_q;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal) begin
            next_state = S_START;
          end else begin
            next_state  = S_DONE;
            next_status = 2'd1;
          end
        end
      end
      S_START: next_state = S_FEED;
      S_FEED: begin
        if (remaining == '0) begin
          // All words already forwarded: a last beat here is a normal finish.
          if (last_hs) begin
            next_state  = S_DONE;
            next_status = 2'd0;
          end else begin
            next_state = S_DRAIN;
          end
        end else if (last_hs) begin
          next_state  = S_DONE;
          next_status = (in_hs && (remaining == LEN_W'(1))) ? 2'd0 : 2'd3;
        end else if (wd_expire) begin
          next_state = S_RECOVER;
        end
      end
      S_DRAIN: begin
        if (last_hs) begin
          next_state  = S_DONE;
          next_status = 2'd0;
        end else if (wd_expire) begin
          next_state = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rec_cnt) begin
          next_state  = S_DONE;
          next_status = 2'd2;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Job registers, word counter, watchdog and recover-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_mode    <= '0;
      job_sec_lvl <= '0;
      remaining   <= '0;
      wd_cnt      <= '0;
      rec_cnt     <= 1'b0;
    end else begin
      if (cmd_fire) begin
        job_mode    <= cmd_mode;
        job_sec_lvl <= cmd_sec_lvl;
        remaining   <= cmd_len;
      end else if (in_hs) begin
        remaining <= remaining - LEN_W'(1);
      end

      if ((state == S_FEED) || (state == S_DRAIN)) begin
        if (in_hs || out_hs) wd_cnt <= '0;
        else                 wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end

      rec_cnt <= (state == S_RECOVER) ? ~rec_cnt : 1'b0;
    end
  end

  // Status and success counter, updated on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= '0;
      jobs_ok_q <= '0;
    end else if ((next_state == S_DONE) && (state != S_DONE)) begin
      status_q <= next_status;
      if (next_status == 2'd0) jobs_ok_q <= jobs_ok_q + 16'd1;
    end
  end

  // Outputs decoded from state plus stream pass-through
  always_comb begin
    cmd_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    core_start   = (state == S_START);
    done         = (state == S_DONE);
    s_ready      = feeding && core_ready_i;
    core_valid_i = feeding && s_valid;
    core_data_i  = s_data;
    core_rst     = !rst_n || (state == S_RECOVER);
    core_mode    = job_mode;
    core_sec_lvl = job_sec_lvl;
    status       = status_q;
    jobs_ok      = jobs_ok_q;
  end

endmodule

// File: tb/tb_dilithium_job_sched.sv
// Directed bench for dilithium_job_sched with a short watchdog.
module tb_dilithium_job_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_mode;
  logic [2:0]  cmd_sec_lvl;
  logic [15:0] cmd_len;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        core_start;
  logic [1:0]  core_mode;
  logic [2:0]  core_sec_lvl;
  logic        core_rst;
  logic        core_valid_i, core_ready_i;
  logic [63:0] core_data_i;
  logic        core_valid_o, core_ready_o, core_last;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] jobs_ok;

  int n_tests = 0;
  int n_fail  = 0;
  int core_words = 0;
  int start_cnt  = 0;
  logic [63:0] core_xor = '0;

  dilithium_job_sched #(.TIMEOUT_CYCLES(16), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_sec_lvl(cmd_sec_lvl), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_start(core_start), .core_mode(core_mode), .core_sec_lvl(core_sec_lvl),
    .core_rst(core_rst), .core_valid_i(core_valid_i), .core_ready_i(core_ready_i),
    .core_data_i(core_data_i), .core_valid_o(core_valid_o), .core_ready_o(core_ready_o),
    .core_last(core_last), .busy(busy), .done(done), .status(status), .jobs_ok(jobs_ok)
  );

  always #5 clk = ~clk;

  // Observe what actually reaches the core
  always @(posedge clk) begin
    if (core_valid_i && core_ready_i) begin
      core_words <= core_words + 1;
      core_xor   <= core_xor ^ core_data_i;
    end
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [2:0] sl, input logic [15:0] len);
    cmd_mode    = m;
    cmd_sec_lvl = sl;
    cmd_len     = len;
    cmd_valid   = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic raise_last(input logic v);
    core_valid_o = v;
    core_ready_o = v;
    core_last    = v;
  endtask

  initial begin
    logic [63:0] words [4];
    logic [63:0] exp_xor;
    logic        tog;
    int          sent;
    int          w0, st0;
    logic [63:0] x0;

    words[0] = 64'h0123_4567_89AB_CDEF;
    words[1] = 64'hFEDC_BA98_7654_3210;
    words[2] = 64'h0000_FFFF_0000_FFFF;
    words[3] = 64'hA5A5_5A5A_C3C3_3C3C;
    exp_xor  = words[0] ^ words[1] ^ words[2] ^ words[3];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_sec_lvl = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; core_ready_i = 1'b0; raise_last(1'b0);

    // Reset values
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_core_valid_i", core_valid_i, 1'b0);
    chk("rst_status", status, 2'd0);
    chk("rst_jobs_ok", jobs_ok, 16'd0);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_core_mode", core_mode, 2'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_core_rst", core_rst, 1'b0);

    // Sign job, four words, core_ready_i toggling
    w0 = core_words; st0 = start_cnt; x0 = core_xor;
    send_cmd(2'd1, 3'd3, 16'd4);
    chk("sign_start", core_start, 1'b1);
    chk("sign_busy", busy, 1'b1);
    chk("sign_mode", core_mode, 2'd1);
    chk("sign_sec", core_sec_lvl, 3'd3);
    step();
    chk("sign_start_low", core_start, 1'b0);
    sent = 0; tog = 1'b0;
    for (int c = 0; c < 40 && sent < 4; c++) begin
      s_valid = 1'b1; s_data = words[sent]; core_ready_i = tog;
      #1;
      chk("sign_s_ready", s_ready, tog);
      chk("sign_core_valid_i", core_valid_i, 1'b1);
      chk("sign_data", core_data_i, words[sent]);
      if (tog) sent++;
      tog = ~tog;
      step();
    end
    chk("sign_all_sent", sent, 4);
    s_valid = 1'b1; core_ready_i = 1'b1;
    #1;
    chk("sign_rem0_s_ready", s_ready, 1'b0);
    chk("sign_rem0_valid_i", core_valid_i, 1'b0);
    step();
    chk("sign_drain_s_ready", s_ready, 1'b0);
    chk("sign_drain_busy", busy, 1'b1);
    s_valid = 1'b0; core_ready_i = 1'b0;
    raise_last(1'b1);
    step();
    raise_last(1'b0);
    chk("sign_done", done, 1'b1);
    chk("sign_status", status, 2'd0);
    chk("sign_jobs_ok", jobs_ok, 16'd1);
    chk("sign_word_cnt", core_words - w0, 4);
    chk("sign_start_cnt", start_cnt - st0, 1);
    chk("sign_xor", core_xor ^ x0, exp_xor);
    step();
    chk("sign_done_pulse", done, 1'b0);
    chk("sign_idle_busy", busy, 1'b0);
    chk("sign_hold_mode", core_mode, 2'd1);
    chk("sign_hold_sec", core_sec_lvl, 3'd3);

    // Illegal commands
    w0 = core_words; st0 = start_cnt;
    s_valid = 1'b1; core_ready_i = 1'b1;
    send_cmd(2'd3, 3'd3, 16'd5);
    chk("ill_mode_done", done, 1'b1);
    chk("ill_mode_status", status, 2'd1);
    chk("ill_mode_s_ready", s_ready, 1'b0);
    step();
    chk("ill_mode_idle", cmd_ready, 1'b1);
    send_cmd(2'd1, 3'd4, 16'd5);
    chk("ill_sec_done", done, 1'b1);
    chk("ill_sec_status", status, 2'd1);
    step();
    chk("ill_start_cnt", start_cnt - st0, 0);
    chk("ill_word_cnt", core_words - w0, 0);
    chk("ill_jobs_ok", jobs_ok, 16'd1);
    chk("ill_status_held", status, 2'd1);
    s_valid = 1'b0; core_ready_i = 1'b0;

    // Zero-length keygen
    w0 = core_words;
    send_cmd(2'd0, 3'd2, 16'd0);
    chk("len0_start", core_start, 1'b1);
    chk("len0_mode", core_mode, 2'd0);
    step();
    s_valid = 1'b1; core_ready_i = 1'b1;
    #1;
    chk("len0_feed_s_ready", s_ready, 1'b0);
    step();
    chk("len0_drain_s_ready", s_ready, 1'b0);
    chk("len0_drain_busy", busy, 1'b1);
    s_valid = 1'b0; core_ready_i = 1'b0;
    raise_last(1'b1);
    step();
    raise_last(1'b0);
    chk("len0_done", done, 1'b1);
    chk("len0_status", status, 2'd0);
    chk("len0_jobs_ok", jobs_ok, 16'd2);
    chk("len0_word_cnt", core_words - w0, 0);
    step();

    // Early last after 3 of 8 words
    w0 = core_words;
    send_cmd(2'd2, 3'd5, 16'd8);
    step();
    s_valid = 1'b1; core_ready_i = 1'b1; s_data = 64'h55;
    step(); step(); step();
    core_ready_i = 1'b0;
    raise_last(1'b1);
    step();
    raise_last(1'b0);
    core_ready_i = 1'b1;
    #1;
    chk("early_done", done, 1'b1);
    chk("early_status", status, 2'd3);
    chk("early_s_ready", s_ready, 1'b0);
    chk("early_jobs_ok", jobs_ok, 16'd2);
    chk("early_word_cnt", core_words - w0, 3);
    step();
    s_valid = 1'b0; core_ready_i = 1'b0;

    // Final input word and last beat in the same cycle
    w0 = core_words;
    send_cmd(2'd1, 3'd2, 16'd2);
    step();
    s_valid = 1'b1; core_ready_i = 1'b1;
    step();
    raise_last(1'b1);
    step();
    raise_last(1'b0);
    s_valid = 1'b0; core_ready_i = 1'b0;
    chk("simul_done", done, 1'b1);
    chk("simul_status", status, 2'd0);
    chk("simul_jobs_ok", jobs_ok, 16'd3);
    chk("simul_word_cnt", core_words - w0, 2);
    step();

    // Watchdog: core never ready in FEED
    send_cmd(2'd1, 3'd5, 16'd4);
    step();
    s_valid = 1'b1; core_ready_i = 1'b0;
    repeat (15) step();
    chk("wd_pre_core_rst", core_rst, 1'b0);
    chk("wd_pre_busy", busy, 1'b1);
    step();
    chk("wd_rec1_core_rst", core_rst, 1'b1);
    step();
    chk("wd_rec2_core_rst", core_rst, 1'b1);
    step();
    chk("wd_after_core_rst", core_rst, 1'b0);
    chk("wd_done", done, 1'b1);
    chk("wd_status", status, 2'd2);
    chk("wd_jobs_ok", jobs_ok, 16'd3);
    step();
    s_valid = 1'b0;

    // Reset mid-FEED, then a clean job
    send_cmd(2'd0, 3'd3, 16'd4);
    step();
    s_valid = 1'b1; core_ready_i = 1'b1;
    #1;
    chk("mid_s_ready_before", s_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_s_ready", s_ready, 1'b0);
    chk("mid_core_rst", core_rst, 1'b1);
    chk("mid_busy", busy, 1'b0);
    chk("mid_jobs_ok", jobs_ok, 16'd0);
    chk("mid_core_mode", core_mode, 2'd0);
    step();
    s_valid = 1'b0; core_ready_i = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_cmd_ready", cmd_ready, 1'b1);
    send_cmd(2'd1, 3'd2, 16'd1);
    step();
    s_valid = 1'b1; core_ready_i = 1'b1; s_data = 64'h77;
    step();
    s_valid = 1'b0; core_ready_i = 1'b0;
    step();
    raise_last(1'b1);
    step();
    raise_last(1'b0);
    chk("post_done", done, 1'b1);
    chk("post_status", status, 2'd0);
    chk("post_jobs_ok", jobs_ok, 16'd1);
    step();
    chk("post_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dilithium_job_sched.md
DILITHIUM_JOB_SCHED -- requirements
Module: dilithium_job_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576, SHALL be the number of idle cycles (no handshake) in FEED/DRAIN before the job is aborted.
REQ-002 Parameter LEN_W, default 16, SHALL be the width of the job input word count.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  job descriptor handshake.
REQ-006 cmd_mode  in  2  operation mode (0 keygen, 1 sign, 2 verify); cmd_sec_lvl  in  3  security level (2, 3 or 5).
REQ-007 cmd_len  in  LEN_W  number of 64-bit host input words to forward to the core; 0 legal.
REQ-008 s_valid/s_ready/s_data  in/out/in  1/1/64  host input stream.
REQ-009 core_start  out  1  start level to the core; core_mode  out  2; core_sec_lvl  out  3; core_rst  out  1  active-high core reset.
REQ-010 core_valid_i/core_ready_i/core_data_i  out/in/out  1/1/64  core input stream.
REQ-011 core_valid_o, core_ready_o, core_last  in  1 each  core output handshake, monitored only.
REQ-012 busy  out  1; done  out  1 pulse; status  out  2 (0 ok, 1 illegal cmd, 2 timeout, 3 early last); jobs_ok  out  16.

Function
REQ-013 FSM states IDLE, START, FEED, DRAIN, RECOVER, DONE; busy=1 in every state except IDLE.
REQ-014 IDLE: cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready latch mode, sec_lvl, len into job registers.
REQ-015 Legality: mode<=2 and sec_lvl in {2,3,5}; illegal -> DONE with status=1, core_start never asserted, no stream words consumed.
REQ-016 Legal cmd -> START; core_start=1 for exactly one cycle, then FEED; core_start=0 in all other states (guarantees a low cycle between jobs for the core's rising-edge start detect).
REQ-017 core_mode/core_sec_lvl SHALL equal latched job values from START through DONE; hold last values in IDLE.
REQ-018 FEED with remaining>0: core_valid_i=s_valid, s_ready=core_ready_i, core_data_i=s_data (combinational pass-through); remaining decrements per s_valid&s_ready.
REQ-019 Outside FEED or with remaining=0: s_ready=0, core_valid_i=0.
REQ-020 FEED -> DRAIN in the cycle after remaining reaches 0; entering FEED with len=0 goes to DRAIN next cycle.
REQ-021 DRAIN: on core_valid_o&core_ready_o&core_last -> DONE, status=0.
REQ-022 Last handshake during FEED with remaining>0 -> DONE, status=3; unforwarded words stay in host stream.
REQ-023 Watchdog: counter cleared on entry to FEED and on any input or output handshake; increments otherwise in FEED/DRAIN; reaching TIMEOUT_CYCLES -> RECOVER.
REQ-024 RECOVER: core_rst=1 for exactly 2 cycles, then DONE with status=2.
REQ-025 DONE: done=1 for one cycle, then IDLE; status updated on DONE entry and held until next DONE.
REQ-026 jobs_ok increments only on status=0 completions, wrapping 16'hFFFF -> 0.
REQ-027 Simultaneous final input handshake and last handshake in FEED SHALL count as ok (status=0).

Reset
REQ-028 rst_n low: state IDLE immediately; busy, done, core_start, core_valid_i, s_ready=0; status=0; jobs_ok=0; counters/job registers=0; core_mode=0, core_sec_lvl=0.
REQ-029 core_rst SHALL equal (~rst_n) OR RECOVER-active, so reset mid-job also resets the core asynchronously.
REQ-030 After rst_n release, cmd_ready=1 on the first clock edge.

Verification
REQ-031 Sign job mode=1, sec_lvl=3, len=4; 4 words fed with core_ready_i toggling; last after -> exactly 4 core words, one core_start pulse, done, status=0, jobs_ok=1.
REQ-032 cmd mode=3 or sec_lvl=4 -> done within 2 cycles, status=1, core_start stays 0, s_ready stays 0, jobs_ok unchanged.
REQ-033 len=0 keygen (mode=0, sec_lvl=2) -> no s_ready, DRAIN, last -> status=0.
REQ-034 TIMEOUT_CYCLES=16, core_ready_i held 0 in FEED -> RECOVER after 16 idle cycles, core_rst high 2 cycles, status=2.
REQ-035 len=8, last after 3 words -> status=3, s_ready deasserts, jobs_ok unchanged.
REQ-036 rst_n low mid-FEED -> same-cycle s_ready=0, core_rst=1; after release, new job completes normally.
